bht_btb: RTL and testbench



---
 rtl/bht_btb.sv | 107 ++++++++++
 tb/tb_bht_btb.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/bht_btb.sv
`default_nettype none
// ============================================================================
// Module      : bht_btb
// Description : Direct-mapped branch history table + branch target buffer.
//               Combinational lookup on the fetch PC, synchronous training.
//               Optional macro BHT_BTB_BYPASS_EN forwards a same-cycle update
//               to a lookup of the same PC.
// Revision    : 1.0 - initial release
// ============================================================================
module bht_btb #(
    parameter int IDX_W = 6,
    parameter int TAG_W = 24
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        update,
    input  logic [31:0] update_pc,
    input  logic        act_taken,
    input  logic [31:0] act_target,
    input  logic        inv_all
);

    localparam int c_entries = 2 ** IDX_W;

    logic             r_valid  [c_entries];
    logic [TAG_W-1:0] r_tag    [c_entries];
    logic [1:0]       r_ctr    [c_entries];
    logic [31:0]      r_target [c_entries];

    logic [IDX_W-1:0] w_idx, w_uidx;
    logic [TAG_W-1:0] w_tag, w_utag;
    logic             w_uhit;
    logic [1:0]       w_nxt_ctr;
    logic [31:0]      w_nxt_target;
    logic             w_we;
    logic             w_hit;
    logic [1:0]       w_ctr;
    logic [31:0]      w_tgt;
    logic             w_unused_bits;

    assign w_idx  = pc[IDX_W+1:2];
    assign w_tag  = pc[31:IDX_W+2];
    assign w_uidx = update_pc[IDX_W+1:2];
    assign w_utag = update_pc[31:IDX_W+2];
    assign w_unused_bits = ^{pc[1:0], update_pc[1:0]};

    assign w_uhit = r_valid[w_uidx] && (r_tag[w_uidx] == w_utag);
    assign w_we   = update && !rst && !inv_all;

    always_comb begin
        w_nxt_ctr = r_ctr[w_uidx];
        if (w_uhit) begin
            if (act_taken) begin
                if (r_ctr[w_uidx] != 2'b11) w_nxt_ctr = r_ctr[w_uidx] + 2'd1;
            end else begin
                if (r_ctr[w_uidx] != 2'b00) w_nxt_ctr = r_ctr[w_uidx] - 2'd1;
            end
        end else if (act_taken) begin
            w_nxt_ctr = 2'b10;
        end
    end

    assign w_nxt_target = act_taken ? act_target : r_target[w_uidx];

    // Valid and counter state carries the reset; tags and targets do not.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < c_entries; i++) begin
                r_valid[i] <= 1'b0;
                r_ctr[i]   <= 2'b01;
            end
        end else if (inv_all) begin
            for (int i = 0; i < c_entries; i++) r_valid[i] <= 1'b0;
        end else if (update && (w_uhit || act_taken)) begin
            r_valid[w_uidx] <= 1'b1;
            r_ctr[w_uidx]   <= w_nxt_ctr;
        end
    end

    always_ff @(posedge clk) begin
        if (w_we && act_taken) begin
            r_tag[w_uidx]    <= w_utag;
            r_target[w_uidx] <= w_nxt_target;
        end
    end

`ifdef BHT_BTB_BYPASS_EN
    logic w_byp;
    assign w_byp = update && !inv_all && (update_pc[31:2] == pc[31:2]);
    assign w_hit = w_byp ? (w_uhit || act_taken)
                         : (r_valid[w_idx] && (r_tag[w_idx] == w_tag));
    assign w_ctr = w_byp ? w_nxt_ctr    : r_ctr[w_idx];
    assign w_tgt = w_byp ? w_nxt_target : r_target[w_idx];
`else
    assign w_hit = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_ctr = r_ctr[w_idx];
    assign w_tgt = r_target[w_idx];
`endif

    assign pred_taken  = w_hit && w_ctr[1] && !rst;
    assign pred_target = pred_taken ? w_tgt : 32'h0;

endmodule
`default_nettype wire

// File: tb/tb_bht_btb.sv
`default_nettype none
// ============================================================================
// Module      : tb_bht_btb
// Description : Self-checking bench for bht_btb: directed plan plus random
//               traffic against a table-of-entries reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bht_btb;

    logic        clk = 1'b0;
    logic        rst, update, act_taken, inv_all;
    logic [31:0] pc, update_pc, act_target;
    logic        pred_taken;
    logic [31:0] pred_target;

    int vectors = 0;
    int miscompares = 0;

    bht_btb dut (
        .clk(clk), .rst(rst), .pc(pc), .pred_taken(pred_taken),
        .pred_target(pred_target), .update(update), .update_pc(update_pc),
        .act_taken(act_taken), .act_target(act_target), .inv_all(inv_all)
    );

    always #5 clk = ~clk;

    // Reference model: one record per index, counters as plain integers 0..3.
    bit      m_valid [64];
    int      m_ctr   [64];
    bit [23:0] m_tag [64];
    bit [31:0] m_tgt [64];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Entry contents after training with the current update inputs.
    task automatic model_next(output bit nv, output int nc, output bit [23:0] ntag, output bit [31:0] ntgt);
        int  i;
        bit  hit;
        i    = int'(update_pc[7:2]);
        hit  = m_valid[i] && (m_tag[i] == update_pc[31:8]);
        nv = m_valid[i]; nc = m_ctr[i]; ntag = m_tag[i]; ntgt = m_tgt[i];
        if (hit && act_taken) begin
            nc = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
            ntgt = act_target;
        end else if (hit) begin
            nc = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
        end else if (act_taken) begin
            nv = 1; nc = 2; ntag = update_pc[31:8]; ntgt = act_target;
        end
    endtask

    task automatic model_lookup(output bit t, output bit [31:0] tg);
        int  i;
        bit  v;
        int  c;
        bit [23:0] tt;
        bit [31:0] gg;
        i = int'(pc[7:2]);
        v = m_valid[i]; c = m_ctr[i]; tt = m_tag[i]; gg = m_tgt[i];
`ifdef BHT_BTB_BYPASS_EN
        if (update && !inv_all && update_pc[31:2] == pc[31:2]) model_next(v, c, tt, gg);
`endif
        t  = !rst && v && (tt == pc[31:8]) && (c >= 2);
        tg = t ? gg : 32'h0;
    endtask

    task automatic model_clock();
        bit nv; int nc; bit [23:0] ntag; bit [31:0] ntgt;
        if (rst) begin
            for (int i = 0; i < 64; i++) begin m_valid[i] = 0; m_ctr[i] = 1; end
        end else if (inv_all) begin
            for (int i = 0; i < 64; i++) m_valid[i] = 0;
        end else if (update) begin
            model_next(nv, nc, ntag, ntgt);
            m_valid[update_pc[7:2]] = nv; m_ctr[update_pc[7:2]] = nc;
            m_tag[update_pc[7:2]] = ntag; m_tgt[update_pc[7:2]] = ntgt;
        end
    endtask

    // One clock: drive, check mid-cycle against model (and optional constant), clock model.
    task automatic cyc(input string tag, input logic [31:0] p, input logic u, input logic [31:0] upc,
                       input logic at, input logic [31:0] atg, input logic inv, input logic r,
                       input bit cchk, input logic ct, input logic [31:0] ctg);
        bit et; bit [31:0] etg;
        pc = p; update = u; update_pc = upc; act_taken = at; act_target = atg;
        inv_all = inv; rst = r;
        @(negedge clk);
        model_lookup(et, etg);
        check({tag, ".taken"}, {31'b0, pred_taken}, {31'b0, et});
        check({tag, ".target"}, pred_target, etg);
        if (cchk) begin
            check({tag, ".c_taken"}, {31'b0, pred_taken}, {31'b0, ct});
            check({tag, ".c_target"}, pred_target, ctg);
        end
        @(posedge clk);
        model_clock();
        #1;
    endtask

    task automatic look(input string tag, input logic [31:0] p, input logic ct, input logic [31:0] ctg);
        cyc(tag, p, 0, 0, 0, 0, 0, 0, 1, ct, ctg);
    endtask

    task automatic train(input string tag, input logic [31:0] upc, input logic at, input logic [31:0] atg);
        cyc(tag, 32'h0, 1, upc, at, atg, 0, 0, 0, 0, 0);
    endtask

    localparam logic [31:0] c_a = 32'hBFC00010;
    localparam logic [31:0] c_b = 32'hBFC00110;
    localparam logic [31:0] c_c = 32'hBFC00020;
    localparam logic [31:0] c_d = 32'hBFC00030;

    initial begin
        logic [31:0] p, up;
        for (int i = 0; i < 64; i++) begin m_valid[i] = 0; m_ctr[i] = 1; end
        #1;
        cyc("reset", c_a, 0, 0, 0, 0, 0, 1, 1, 0, 32'h0);
        cyc("reset2", c_a, 1, c_a, 1, 32'h1234, 0, 1, 1, 0, 32'h0);
        look("post_reset", c_a, 0, 32'h0);
        train("alloc", c_a, 1, 32'hBFC00100);
        look("alloc_hit", c_a, 1, 32'hBFC00100);
        train("nt1", c_a, 0, 0);
        look("ctr01", c_a, 0, 32'h0);
        train("t1", c_a, 1, 32'hBFC00100);
        train("t2", c_a, 1, 32'hBFC00100);
        train("t3", c_a, 1, 32'hBFC00100);
        look("ctr11", c_a, 1, 32'hBFC00100);
        train("nt2", c_a, 0, 0);
        look("ctr10", c_a, 1, 32'hBFC00100);
        train("alias", c_b, 1, 32'h80000000);
        look("alias_old", c_a, 0, 32'h0);
        look("alias_new", c_b, 1, 32'h80000000);
        train("noalloc", c_c, 0, 0);
        look("noalloc_look", c_c, 0, 32'h0);
        cyc("inv_same", c_b, 1, c_b, 1, 32'h5555, 1, 0, 1, 1, 32'h80000000);
        look("inv_after", c_b, 0, 32'h0);
`ifdef BHT_BTB_BYPASS_EN
        cyc("same_cyc", c_d, 1, c_d, 1, 32'hBFC00200, 0, 0, 1, 1, 32'hBFC00200);
`else
        cyc("same_cyc", c_d, 1, c_d, 1, 32'hBFC00200, 0, 0, 1, 0, 32'h0);
`endif
        look("same_next", c_d, 1, 32'hBFC00200);
        cyc("rst_mid", c_d, 0, 0, 0, 0, 0, 1, 1, 0, 32'h0);
        look("rst_after", c_d, 0, 32'h0);

        // Random traffic over a small pool of tags/indices so hits and aliases are common.
        for (int n = 0; n < 3000; n++) begin
            p  = {16'hBFC0, 6'd0, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                  4'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
            up = ($urandom_range(0, 3) == 0) ? {p[31:2], 2'($urandom_range(0, 3))}
               : {16'hBFC0, 6'd0, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                  4'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
            cyc("rand", p, 1'($urandom_range(0, 1)), up, 1'($urandom_range(0, 1)), $urandom,
                ($urandom_range(0, 63) == 0), ($urandom_range(0, 127) == 0), 0, 0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
